branch_resolve_unit: RTL and testbench

//  Producer side of the BTB update interface; sits at EX.
//  - IF pushes each predicted control instruction: pc, predicted taken, predicted target.
//  - EX resolves entries in program order.
//  - Per resolve: compares against the prediction, emits a BTB write (source/target pc) for

---
 rtl/bru_pkg.sv | 13 +
 rtl/bru_if.sv | 34 +++
 rtl/bru_pred_fifo.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: prediction queue entry and pc step.
package bru_pkg;

  localparam int BRU_PC_W = 32;
  localparam int PC_INC   = 4;

  typedef struct packed {
    logic [BRU_PC_W-1:0] pc;
    logic                pred_taken;
    logic [BRU_PC_W-1:0] pred_target;
  } bru_entry_t;

endpackage

// File: rtl/bru_if.sv
// Push (IF), resolve (EX) and BTB-update/redirect signals of the branch resolve unit.
interface bru_if #(
  parameter int PC_W = 32
);
  logic            push_valid;
  logic            push_ready;
  logic [PC_W-1:0] push_pc;
  logic            push_pred_taken;
  logic [PC_W-1:0] push_pred_target;
  logic            resolve_valid;
  logic            resolve_taken;
  logic [PC_W-1:0] resolve_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_source_pc;
  logic [PC_W-1:0] upd_target_pc;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            empty;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output resolve_valid, resolve_taken, resolve_target,
    input  push_ready, upd_valid, upd_source_pc, upd_target_pc,
    input  redirect_valid, redirect_pc, flush, empty
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  resolve_valid, resolve_taken, resolve_target,
    output push_ready, upd_valid, upd_source_pc, upd_target_pc,
    output redirect_valid, redirect_pc, flush, empty
  );
endinterface

// File: rtl/bru_pred_fifo.sv
// In-order queue of in-flight predictions; clear empties it and drops a same-cycle push.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  bru_entry_t push_data,
  input  logic       pop,
  input  logic       clear,
  output logic       full,
  output logic       empty,
  output bru_entry_t head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  bru_entry_t  r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer bit flips on each wrap so equal indices can mean full or empty.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push && !full && !clear;
  assign w_do_pop  = pop && !empty && !clear;
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted control instructions at EX, emitting BTB updates and redirects.
// Optional BRU_STATS_EN adds branch / mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BRU_PC_W
) (
  input  logic        clk,
  input  logic        reset,
  bru_if.slave        bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  // Entry layout lives in the package, so the pc width is fixed there.
  if (PC_W != BRU_PC_W) begin : g_bad_pc_w
    $error("branch_resolve_unit: PC_W must equal bru_pkg::BRU_PC_W");
  end

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_accept;
  logic            w_mispredict;
  bru_entry_t      w_head;
  bru_entry_t      w_push_entry;

  logic            r_upd_valid;
  logic [PC_W-1:0] r_upd_source_pc;
  logic [PC_W-1:0] r_upd_target_pc;
  logic            r_redirect_valid;
  logic [PC_W-1:0] r_redirect_pc;

  assign bus.push_ready = !w_full && !reset;
  assign w_push         = bus.push_valid && bus.push_ready;
  assign w_accept       = bus.resolve_valid && !w_empty;
  assign w_mispredict   = (w_head.pred_taken != bus.resolve_taken) ||
                          (w_head.pred_taken && bus.resolve_taken &&
                           (w_head.pred_target != bus.resolve_target));

  assign w_push_entry.pc          = bus.push_pc;
  assign w_push_entry.pred_taken  = bus.push_pred_taken;
  assign w_push_entry.pred_target = bus.push_pred_target;

  bru_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_accept),
    .clear     (w_accept && w_mispredict),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd_valid      <= 1'b0;
      r_upd_source_pc  <= '0;
      r_upd_target_pc  <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_upd_valid      <= w_accept && bus.resolve_taken;
      r_redirect_valid <= w_accept && w_mispredict;
      if (w_accept) begin
        r_upd_source_pc <= w_head.pc;
        r_upd_target_pc <= bus.resolve_target;
        r_redirect_pc   <= bus.resolve_taken ? bus.resolve_target
                                             : w_head.pc + PC_W'(PC_INC);
      end
    end
  end

  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_source_pc  = r_upd_source_pc;
  assign bus.upd_target_pc  = r_upd_target_pc;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush          = r_redirect_valid;
  assign bus.empty          = w_empty;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_accept) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + random bench for branch_resolve_unit against a queue-based model.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bru_if #(.PC_W(PC_W)) bif ();

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bif.slave)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  logic        e_upd;
  logic [31:0] e_src;
  logic [31:0] e_tgt;
  logic        e_redir;
  logic [31:0] e_rpc;
  logic [31:0] m_branches;
  logic [31:0] m_mispred;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Model: what the outputs must be after the coming edge, from the queue contents.
  task automatic model(input logic rst, input logic pv, input logic [31:0] ppc,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic rv, input logic rtk, input logic [31:0] rtgt);
    logic   ok_push;
    logic   mis;
    m_ent_t h;
    if (rst) begin
      mq.delete();
      e_upd = 0; e_redir = 0; e_src = 0; e_tgt = 0; e_rpc = 0;
      m_branches = 0; m_mispred = 0;
      return;
    end
    ok_push = pv && (mq.size() < DEPTH);
    e_upd   = 0;
    e_redir = 0;
    if (rv && mq.size() > 0) begin
      h     = mq.pop_front();
      mis   = (h.tk != rtk) || (h.tk && rtk && h.tgt != rtgt);
      e_upd = rtk;
      e_src = h.pc;
      e_tgt = rtgt;
      m_branches++;
      if (mis) begin
        e_redir = 1;
        e_rpc   = rtk ? rtgt : h.pc + 32'd4;
        m_mispred++;
        mq.delete();
        ok_push = 0;
      end
    end
    if (ok_push) mq.push_back('{pc: ppc, tk: ptk, tgt: ptgt});
  endtask

  task automatic compare();
    chk("upd_valid", 32'(bif.upd_valid), 32'(e_upd));
    if (e_upd) begin
      chk("upd_source_pc", bif.upd_source_pc, e_src);
      chk("upd_target_pc", bif.upd_target_pc, e_tgt);
    end
    chk("redirect_valid", 32'(bif.redirect_valid), 32'(e_redir));
    chk("flush", 32'(bif.flush), 32'(e_redir));
    if (e_redir) chk("redirect_pc", bif.redirect_pc, e_rpc);
    chk("empty", 32'(bif.empty), 32'(mq.size() == 0));
`ifdef BRU_STATS_EN
    chk("stat_branches", stat_branches, m_branches);
    chk("stat_mispredicts", stat_mispredicts, m_mispred);
`endif
  endtask

  task automatic step(input logic rst, input logic pv, input logic [31:0] ppc,
                      input logic ptk, input logic [31:0] ptgt,
                      input logic rv, input logic rtk, input logic [31:0] rtgt);
    @(negedge clk);
    reset                = rst;
    bif.push_valid       = pv;
    bif.push_pc          = ppc;
    bif.push_pred_taken  = ptk;
    bif.push_pred_target = ptgt;
    bif.resolve_valid    = rv;
    bif.resolve_taken    = rtk;
    bif.resolve_target   = rtgt;
    #1;
    chk("push_ready", 32'(bif.push_ready), 32'(!rst && mq.size() < DEPTH));
    model(rst, pv, ppc, ptk, ptgt, rv, rtk, rtgt);
    @(posedge clk);
    #1;
    compare();
    bif.push_valid    = 0;
    bif.resolve_valid = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    step(0, 1, pc, tk, tgt, 0, 0, 0);
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    step(0, 0, 0, 0, 0, 1, tk, tgt);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1;
    bif.push_valid = 0; bif.push_pc = 0; bif.push_pred_taken = 0; bif.push_pred_target = 0;
    bif.resolve_valid = 0; bif.resolve_taken = 0; bif.resolve_target = 0;

    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(bif.empty), 32'd1);
    chk("rst_upd_src", bif.upd_source_pc, 32'd0);
    chk("rst_redirect_pc", bif.redirect_pc, 32'd0);

    // 1: correct not-taken prediction
    push(32'h100, 0, 0);
    resolve(0, 32'h0);
    chk("t1_upd", 32'(bif.upd_valid), 32'd0);
    chk("t1_redir", 32'(bif.redirect_valid), 32'd0);
    chk("t1_empty", 32'(bif.empty), 32'd1);

    // 2: predicted NT, actually taken
    push(32'h200, 0, 0);
    resolve(1, 32'h400);
    chk("t2_upd", 32'(bif.upd_valid), 32'd1);
    chk("t2_src", bif.upd_source_pc, 32'h200);
    chk("t2_tgt", bif.upd_target_pc, 32'h400);
    chk("t2_rpc", bif.redirect_pc, 32'h400);
    chk("t2_flush", 32'(bif.flush), 32'd1);
    idle();
    chk("t2_single_cycle", 32'(bif.flush), 32'd0);

    // 3: wrong target, younger entries discarded
    push(32'h300, 1, 32'h500);
    push(32'h310, 0, 0);
    push(32'h320, 0, 0);
    push(32'h330, 0, 0);
    resolve(1, 32'h600);
    chk("t3_src", bif.upd_source_pc, 32'h300);
    chk("t3_tgt", bif.upd_target_pc, 32'h600);
    chk("t3_rpc", bif.redirect_pc, 32'h600);
    chk("t3_empty", 32'(bif.empty), 32'd1);

    // 4: predicted taken, actually not taken
    push(32'h700, 1, 32'h800);
    resolve(0, 32'h0);
    chk("t4_rpc", bif.redirect_pc, 32'h704);
    chk("t4_upd", 32'(bif.upd_valid), 32'd0);

    // fall-through pc wraps at the top of the address space
    push(32'hFFFF_FFFC, 1, 32'h10);
    resolve(0, 32'h0);
    chk("wrap_rpc", bif.redirect_pc, 32'h0);

    // 5: full queue, push+resolve together does not push
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i) * 4, 0, 0);
    chk("t5_full_ready", 32'(bif.push_ready), 32'd0);
    step(0, 1, 32'h2000, 0, 0, 1, 0, 0);
    chk("t5_one_pop_ready", 32'(bif.push_ready), 32'd1);
    chk("t5_nonempty", 32'(bif.empty), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) resolve(0, 0);
    chk("t5_drained", 32'(bif.empty), 32'd1);
    resolve(1, 32'h44);
    chk("t5_empty_resolve_upd", 32'(bif.upd_valid), 32'd0);
    chk("t5_empty_resolve_redir", 32'(bif.redirect_valid), 32'd0);

    // 6: reset right after a mispredicting resolve
    push(32'h900, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'hA00);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_upd", 32'(bif.upd_valid), 32'd0);
    chk("t6_redir", 32'(bif.redirect_valid), 32'd0);
    chk("t6_empty", 32'(bif.empty), 32'd1);
`ifdef BRU_STATS_EN
    chk("t6_stat_b", stat_branches, 32'd0);
    chk("t6_stat_m", stat_mispredicts, 32'd0);
`endif

    // random traffic; small target set so correct predictions are common
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        pv;
      logic        ptk;
      logic        rv;
      logic        rtk;
      logic [31:0] ppc;
      logic [31:0] ptgt;
      logic [31:0] rtgt;
      r    = ($urandom_range(0, 199) == 0);
      pv   = ($urandom_range(0, 99) < 60);
      ppc  = {$urandom_range(0, 1023), 2'b00} | 32'(($urandom_range(0, 7) == 0) ? 32'hFFFF_F000 : 0);
      ptk  = $urandom_range(0, 1) != 0;
      ptgt = 32'($urandom_range(0, 3)) * 32'h40;
      rv   = ($urandom_range(0, 99) < 40);
      rtk  = ($urandom_range(0, 99) < 50);
      rtgt = 32'($urandom_range(0, 3)) * 32'h40;
      if ($urandom_range(0, 3) != 0 && mq.size() > 0) begin
        rtk = mq[0].tk;
        if (rtk) rtgt = mq[0].tgt;
      end
      step(r, pv, ppc, ptk, ptgt, rv, rtk, rtgt);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
